// File: rtl/kv32_pkg.sv
// Shared encodings for the kv32 load/store path: access sizes, LSU FSM states
// and the alignment rule.
package kv32_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_e;

    // True for any access that must be rejected without touching the bus.
    function automatic logic is_bad_access(input size_e sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and byte/half extraction with
// sign or zero extension for loads.
module lsu_align
    import kv32_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_we,
    output logic [31:0] st_lanes,
    input  size_e       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_we    = 4'b0000;
        st_lanes = 32'h0;
        case (st_size)
            SZ_BYTE: begin
                st_we    = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_we    = st_off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            SZ_WORD: begin
                st_we    = 4'b1111;
                st_lanes = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

        ld_data = 32'h0;
        case (ld_size)
            SZ_BYTE: begin
                if (ld_unsigned) ld_data = {24'h0, ld_byte};
                else             ld_data = 32'(ld_byte);
            end
            SZ_HALF: begin
                if (ld_unsigned) ld_data = {16'h0, ld_half};
                else             ld_data = 32'(ld_half);
            end
            SZ_WORD: ld_data = ld_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core access at a time, drives a word-wide bus
// with lane enables, and returns an extended load word or an error pulse.
module lsu
    import kv32_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        bus_en,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e         state;
    logic [CNT_W-1:0] cnt;
    size_e          size_q;
    logic [1:0]     off_q;
    logic           uns_q;
    logic           wr_q;
    logic [3:0]     st_we;
    logic [31:0]    st_lanes;
    logic [31:0]    ld_data;
    logic           timeout_hit;

    lsu_align u_align (
        .st_size     (size_e'(req_size)),
        .st_off      (req_addr[1:0]),
        .st_data     (req_wdata),
        .st_we       (st_we),
        .st_lanes    (st_lanes),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_word     (bus_rdata),
        .ld_data     (ld_data)
    );

    // A load accepted on the last REQ cycle enters WAIT already past the limit,
    // so ">=" still gives it exactly one cycle in which rvalid can win.
    assign timeout_hit = (cnt >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            bus_en    <= 1'b0;
            bus_we    <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q    <= size_e'(req_size);
                        off_q     <= req_addr[1:0];
                        uns_q     <= req_unsigned;
                        wr_q      <= req_wr;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_wdata <= st_lanes;
                        bus_we    <= req_wr ? st_we : 4'b0000;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_bad_access(size_e'(req_size), req_addr[1:0])) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state  <= REQ;
                            bus_en <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_en <= 1'b0;
                        cnt    <= cnt + CNT_W'(1);
                        if (wr_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        bus_en    <= 1'b0;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ld_data;
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for the bus before an error response.
REQ-003 Ports SHALL be, in order:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - req_valid  in  1  core access request
  - req_ready  out  1  request accepted when valid&ready
  - req_wr  in  1  1=store, 0=load
  - req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
  - req_unsigned  in  1  zero-extend load (LBU/LHU)
  - req_addr  in  32  byte address
  - req_wdata  in  32  store data, LSB-aligned
  - rsp_valid  out  1  one-cycle completion pulse
  - rsp_rdata  out  32  extended load data
  - rsp_err  out  1  misaligned, illegal size or timeout; qualified by rsp_valid
  - busy  out  1  access in flight (core stall)
  - bus_en  out  1  bus request
  - bus_ready  in  1  bus accepts when bus_en&bus_ready
  - bus_addr  out  32  word address, bits[1:0]=0
  - bus_we  out  4  byte-lane write enables
  - bus_wdata  out  32  lane-steered store data
  - bus_rvalid  in  1  read data valid
  - bus_rdata  in  32  read word

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in REQ, WAIT and RESP.
REQ-006 On an accepted request, the block SHALL register address, size, unsigned, wr and steered data in the same cycle.
REQ-007 A misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go IDLE->RESP with rsp_err=1 and never assert bus_en.
REQ-008 A legal request SHALL go IDLE->REQ; in REQ, bus_en SHALL be 1 and addr/we/wdata SHALL be held stable until bus_ready=1.
REQ-009 Store lanes: byte -> bus_we=1<<addr[1:0] with data replicated into all bytes; half -> bus_we=0011 or 1100 with data replicated into both halves; word -> bus_we=1111.
REQ-010 Loads SHALL drive bus_we=0000.
REQ-011 On acceptance, a store SHALL go REQ->RESP and a load SHALL go REQ->WAIT.
REQ-012 In WAIT, bus_rvalid=1 SHALL capture bus_rdata and go to RESP; bus_rvalid outside WAIT SHALL be ignored.
REQ-013 Load extraction: select the byte/half addressed by addr[1:0]; sign-extend unless req_unsigned=1; a word passes unchanged.
REQ-014 A cycle counter SHALL clear on entry to REQ and count in REQ and WAIT; reaching TIMEOUT SHALL go to RESP with rsp_err=1 and bus_en deasserted.
REQ-015 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-016 rsp_rdata SHALL be 0 for stores and errors.
REQ-017 Minimum latency: a zero-wait store (bus_ready already 1) SHALL pulse rsp_valid 2 cycles after acceptance; a load with rvalid on the cycle after acceptance SHALL pulse rsp_valid 3 cycles after acceptance.
REQ-018 bus_rvalid arriving in the same cycle the timeout hits SHALL win: data is returned with rsp_err=0.

Reset
REQ-019 rst SHALL force IDLE, clear the counter and drive outputs to: req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus_en=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-020 Reset asserted mid-access SHALL abandon the access with no rsp_valid pulse; any later bus_rvalid SHALL be ignored.

Structure
REQ-021 The size encoding and the state enum SHALL be defined in the shared package kv32_pkg.
REQ-022 Lane steering, write-enable generation and load extension SHALL be a combinational sub-module lsu_align.

Verification
REQ-023 SB to addr 0x103 with wdata 0xAB -> bus_we=1000, bus_wdata=0xABABABAB, bus_addr=0x100, rsp_valid 2 cycles after acceptance, rsp_err=0.
REQ-024 LH from 0x102 with bus_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; LHU from the same address -> rsp_rdata=0x00008001.
REQ-025 LW from 0x101 -> rsp_err=1, bus_en never asserted, rsp_valid one cycle after acceptance.
REQ-026 bus_ready held low for 5 cycles on SW -> bus_addr, bus_we and bus_wdata stable throughout; a single rsp_valid pulse follows.
REQ-027 With TIMEOUT=4 and no bus_rvalid -> rsp_err=1 after 4 wait cycles; bus_rvalid arriving in the timeout cycle -> data returned, rsp_err=0.
REQ-028 rst asserted while in WAIT -> next cycle IDLE, req_ready=1, no rsp_valid; a late bus_rvalid is ignored.
